// File: rtl/id_ex_hazard_stage_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipe_pkg
// Shared definitions for the RV32I ID/EX pipeline stage:
//   - forwarding select encodings (FWD_NONE / FWD_MEMWB / FWD_EXMEM)
//   - bit positions inside the opaque ID/EX control bundle
//   - default datapath / register-index / control widths
// ---------------------------------------------------------------------------
package rv_pipe_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CTRL_W_DEF  = 8;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  // Control bundle layout: [0] reg_write, [1] mem_read, [2] alu_src,
  // [6:3] alu_sel, [7] spare (passed through untouched).
  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_MEM_READ    = 1;
  localparam int CTRL_ALU_SRC     = 2;
  localparam int CTRL_ALU_SEL_LSB = 3;
  localparam int CTRL_ALU_SEL_W   = 4;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_if
// Bundles the decode-side inputs, the EX/MEM and MEM/WB writeback taps and
// the EX-side outputs of the ID/EX stage.
//   master : decode / later-stage side (drives id_*, exmem_*, memwb_*)
//   slave  : the ID/EX stage (drives ex_*, op_a/op_b, store_data, fwd_a/b)
// ---------------------------------------------------------------------------
interface id_ex_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 8
);
  logic               id_valid;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic [RADDR_W-1:0] id_rd;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [XLEN-1:0]    id_rs1_data;
  logic [XLEN-1:0]    id_rs2_data;
  logic [XLEN-1:0]    id_imm;
  logic [CTRL_W-1:0]  id_ctrl;

  logic [RADDR_W-1:0] exmem_rd;
  logic               exmem_reg_write;
  logic [XLEN-1:0]    exmem_result;
  logic [RADDR_W-1:0] memwb_rd;
  logic               memwb_reg_write;
  logic [XLEN-1:0]    memwb_data;

  logic               ex_valid;
  logic [RADDR_W-1:0] ex_rd;
  logic [CTRL_W-1:0]  ex_ctrl;
  logic [XLEN-1:0]    ex_imm;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [XLEN-1:0]    store_data;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_ctrl,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_data,
    input  ex_valid, ex_rd, ex_ctrl, ex_imm, op_a, op_b, store_data,
           fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_ctrl,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_data,
    output ex_valid, ex_rd, ex_ctrl, ex_imm, op_a, op_b, store_data,
           fwd_a, fwd_b
  );
endinterface

// File: rtl/id_ex_hazard_stage_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Picks the forwarding source for one source register index.
//   rs_i                     : source register index being read
//   exmem_rd_i / exmem_we_i  : EX/MEM destination and write enable
//   memwb_rd_i / memwb_we_i  : MEM/WB destination and write enable
//   sel_o                    : FWD_EXMEM, FWD_MEMWB or FWD_NONE
// EX/MEM holds the younger result, so it wins; x0 never forwards.
// ---------------------------------------------------------------------------
module fwd_select
  import rv_pipe_pkg::*;
#(
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic [RADDR_W-1:0] rs_i,
  input  logic [RADDR_W-1:0] exmem_rd_i,
  input  logic               exmem_we_i,
  input  logic [RADDR_W-1:0] memwb_rd_i,
  input  logic               memwb_we_i,
  output logic [1:0]         sel_o
);

  always_comb begin
    sel_o = FWD_NONE;
    if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
      sel_o = FWD_EXMEM;
    end else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register for the RV32I core with load-use stall detection,
// EX/MEM + MEM/WB operand forwarding and a WB->ID write-through bypass.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   en       : global advance; 0 holds every register
//   flush    : squash the instruction entering EX (bubble)
//   stall_o  : load-use stall request to PC / IF-ID
//   bus      : id_ex_if.slave - decode inputs, writeback taps, EX outputs
// Register update priority: rst > !en > flush > stall_o > capture.
// ---------------------------------------------------------------------------
module id_ex_hazard_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CTRL_W  = CTRL_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  input  logic    flush,
  output logic    stall_o,
  id_ex_if.slave  bus
);

  logic               ex_valid_q, ex_valid_d;
  logic [RADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic [RADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [RADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [CTRL_W-1:0]  ex_ctrl_q, ex_ctrl_d;
  logic [XLEN-1:0]    ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]    ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]    ex_rs2_data_q, ex_rs2_data_d;

  logic [1:0]         byp1_sel, byp2_sel;
  logic [1:0]         fwd_a_sel, fwd_b_sel;
  logic               hit_rs1, hit_rs2;
  logic [XLEN-1:0]    rs1_fwd, rs2_fwd;

  // ---- ID side: WB->ID bypass and load-use detection ----
  // The register bank is written at the end of WB, so a same-cycle read
  // returns stale data; the MEM/WB tap with EX/MEM disabled tells us when.
  fwd_select #(.RADDR_W(RADDR_W)) u_byp_rs1 (
    .rs_i       (bus.id_rs1),
    .exmem_rd_i ('0),
    .exmem_we_i (1'b0),
    .memwb_rd_i (bus.memwb_rd),
    .memwb_we_i (bus.memwb_reg_write),
    .sel_o      (byp1_sel)
  );

  fwd_select #(.RADDR_W(RADDR_W)) u_byp_rs2 (
    .rs_i       (bus.id_rs2),
    .exmem_rd_i ('0),
    .exmem_we_i (1'b0),
    .memwb_rd_i (bus.memwb_rd),
    .memwb_we_i (bus.memwb_reg_write),
    .sel_o      (byp2_sel)
  );

  assign hit_rs1 = bus.id_use_rs1 && (bus.id_rs1 == ex_rd_q);
  assign hit_rs2 = bus.id_use_rs2 && (bus.id_rs2 == ex_rd_q);

  // A squashed ID instruction cannot need load data, so flush masks the stall.
  assign stall_o = !flush && ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] &&
                   bus.id_valid && (ex_rd_q != '0) && (hit_rs1 || hit_rs2);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_rd_d       = ex_rd_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    if (en) begin
      if (flush || stall_o) begin
        // Bubble: clearing ctrl kills reg_write/mem_read, which also ends
        // the stall after exactly one cycle.
        ex_valid_d    = 1'b0;
        ex_rd_d       = '0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_ctrl_d     = '0;
        ex_imm_d      = '0;
        ex_rs1_data_d = '0;
        ex_rs2_data_d = '0;
      end else begin
        ex_valid_d    = bus.id_valid;
        ex_rd_d       = bus.id_rd;
        ex_rs1_d      = bus.id_rs1;
        ex_rs2_d      = bus.id_rs2;
        ex_ctrl_d     = bus.id_ctrl;
        ex_imm_d      = bus.id_imm;
        ex_rs1_data_d = (byp1_sel == FWD_MEMWB) ? bus.memwb_data : bus.id_rs1_data;
        ex_rs2_data_d = (byp2_sel == FWD_MEMWB) ? bus.memwb_data : bus.id_rs2_data;
      end
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_ctrl_q     <= '0;
      ex_imm_q      <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_rd_q       <= ex_rd_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
    end
  end

  // ---- EX side: operand forwarding and ALU operand select ----
  fwd_select #(.RADDR_W(RADDR_W)) u_fwd_a (
    .rs_i       (ex_rs1_q),
    .exmem_rd_i (bus.exmem_rd),
    .exmem_we_i (bus.exmem_reg_write),
    .memwb_rd_i (bus.memwb_rd),
    .memwb_we_i (bus.memwb_reg_write),
    .sel_o      (fwd_a_sel)
  );

  fwd_select #(.RADDR_W(RADDR_W)) u_fwd_b (
    .rs_i       (ex_rs2_q),
    .exmem_rd_i (bus.exmem_rd),
    .exmem_we_i (bus.exmem_reg_write),
    .memwb_rd_i (bus.memwb_rd),
    .memwb_we_i (bus.memwb_reg_write),
    .sel_o      (fwd_b_sel)
  );

  always_comb begin
    rs1_fwd = ex_rs1_data_q;
    case (fwd_a_sel)
      FWD_EXMEM: rs1_fwd = bus.exmem_result;
      FWD_MEMWB: rs1_fwd = bus.memwb_data;
      default:   rs1_fwd = ex_rs1_data_q;
    endcase
  end

  always_comb begin
    rs2_fwd = ex_rs2_data_q;
    case (fwd_b_sel)
      FWD_EXMEM: rs2_fwd = bus.exmem_result;
      FWD_MEMWB: rs2_fwd = bus.memwb_data;
      default:   rs2_fwd = ex_rs2_data_q;
    endcase
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_ctrl    = ex_ctrl_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.op_a       = rs1_fwd;
  // Stores still need the forwarded rs2 even when op_b carries the immediate.
  assign bus.op_b       = ex_ctrl_q[CTRL_ALU_SRC] ? ex_imm_q : rs2_fwd;
  assign bus.store_data = rs2_fwd;
  assign bus.fwd_a      = fwd_a_sel;
  assign bus.fwd_b      = fwd_b_sel;

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- Parametrised ID/EX pipeline stage for the RV32I core, replacing the fixed-width test-only forwarding logic.
- Registers decoded ID-stage operands and control, and detects load-use hazards by emitting a stall plus bubble.
- Applies EX/MEM and MEM/WB forwarding to the registered operands, and applies a WB→ID write-through bypass on capture.
- Sits between the decode/register-bank logic and the ALU; the ALU consumes op_a/op_b directly.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register index width.
- CTRL_W, 8, width of opaque control bundle passed through ID/EX; bit positions defined in package.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global pipeline advance; 0 holds all state.
- flush  in  1  branch/jump squash of the instruction entering EX.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs1, id_rs2, id_rd  in  RADDR_W  decoded register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data  in  XLEN  register-bank read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle (reg_write, mem_read, alu_src, alu_sel...).
- exmem_rd  in  RADDR_W; exmem_reg_write  in  1; exmem_result  in  XLEN.
- memwb_rd  in  RADDR_W; memwb_reg_write  in  1; memwb_data  in  XLEN.
- stall_o  out  1  load-use stall to PC/IF-ID (hold).
- ex_valid  out  1; ex_rd  out  RADDR_W; ex_ctrl  out  CTRL_W; ex_imm  out  XLEN.
- op_a, op_b  out  XLEN  ALU operands after forwarding and alu_src select.
- store_data  out  XLEN  forwarded rs2 for stores.
- fwd_a, fwd_b  out  2  forwarding selects, for debug/verification.

Behaviour:
- Reset: all ID/EX registers clear to 0, so ex_valid=0, ex_ctrl=0, ex_rd=0 and ex_imm=0. Consequently stall_o=0, fwd_a=fwd_b=00 and op_a=0 on the first cycle after reset. rst overrides en and flush.
- Register update priority at each posedge: rst > !en (hold) > flush (bubble) > stall_o (bubble) > capture.
- Bubble: ex_valid=0 and ex_ctrl=0, so reg_write and mem_read are 0. Other fields are don't-care but are zeroed.
- Capture: all id_* fields latch; ex_valid=id_valid. Latency ID→EX is exactly 1 cycle.
- WB→ID bypass on capture: if memwb_reg_write, memwb_rd!=0 and memwb_rd==id_rs1, the registered rs1 data is memwb_data instead of id_rs1_data. The same rule applies to rs2.
- Load-use stall (combinational): stall_o=1 when all of the following hold:
  - ex_valid, ex_ctrl.mem_read and id_valid;
  - ex_rd!=0;
  - (id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd).
  - stall_o is forced 0 when flush=1.
- stall_o lasts exactly one cycle per hazard: the inserted bubble clears mem_read.
- With en=0, stall_o is still evaluated but the state does not move.
- Forwarding (combinational, per operand on the registered rs1/rs2):
  - EXMEM (10) when exmem_reg_write & exmem_rd!=0 & exmem_rd==rsX.
  - Else MEMWB (01) when memwb_reg_write & memwb_rd!=0 & memwb_rd==rsX.
  - Else NONE (00).
  - EX/MEM wins over MEM/WB when both match. x0 is never forwarded.
- op_a = forwarded rs1. op_b = ex_ctrl.alu_src ? ex_imm : forwarded rs2. store_data = forwarded rs2 regardless of alu_src.
- Forwarding and stall are independent of ex_valid for the muxes. Only the stall requires ex_valid.
- All arithmetic is equality compare only; no width extension inside the block.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - FWD_NONE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10;
  - control-bundle bit indices CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_ALU_SRC, and the CTRL_ALU_SEL field;
  - XLEN/RADDR_W defaults.
- One sub-module, fwd_select: inputs rs, exmem_rd/we, memwb_rd/we; output 2-bit select. It is instantiated twice (A, B) and reused for the WB→ID bypass compare.

Test Plan:
- Reset: assert rst 2 cycles with id_valid=1 → ex_valid=0, ex_ctrl=0, stall_o=0, op_a=0. Deassert → next edge captures the id_* values.
- EX/MEM priority: ex rs1=5, exmem_rd=5/we=1/result=0xAAAA0001, memwb_rd=5/we=1/data=0xBBBB0002 → fwd_a=10, op_a=0xAAAA0001. Drop exmem_we → fwd_a=01, op_a=0xBBBB0002.
- x0 guard: rs2=0, exmem_rd=0, we=1, result=0xFFFFFFFF, alu_src=0 → fwd_b=00, op_b=the registered rs2 data.
- Load-use: EX holds a load with rd=7 and mem_read=1; ID has rs2=7 with id_use_rs2=1 → stall_o=1 for exactly 1 cycle. The next EX shows ex_valid=0, ctrl=0. The cycle after captures the dependent instruction.
- Flush vs stall: same hazard plus flush=1 → stall_o=0 and a bubble is inserted. en=0 during any of the above → all ex_* outputs hold their values.
- WB bypass: id_rs1=9, id_rs1_data=0x11, memwb_rd=9/we=1/data=0x22 at the capture edge, then the WB regs clear → op_a=0x22 with fwd_a=00.
